lock_sequencer: RTL and testbench

// Lock control FSM directly upstream of the LED blink controller. Collects press symbols
// (short/long) from the press classifier, compares a CODE_LEN sequence against a stored code,

---
 rtl/lock_sequencer_pkg.sv | 35 +++
 rtl/lock_timeout_timer.sv | 24 ++
 rtl/lock_sequencer.sv | 173 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_sequencer_pkg.sv
// rtl/lock_sequencer_pkg.sv - shared states, symbol/blink encodings and timing defaults for the lock sequencer
package lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENTER      = 3'd1,
        ST_CHECK      = 3'd2,
        ST_UNLOCKED   = 3'd3,
        ST_PROG_ENTER = 3'd4,
        ST_SIGNAL     = 3'd5,
        ST_WAIT_BLINK = 3'd6
    } state_t;

    localparam logic BLINK_ERROR   = 1'b0;
    localparam logic BLINK_PROG_OK = 1'b1;
    localparam logic SYM_SHORT     = 1'b0;
    localparam logic SYM_LONG      = 1'b1;

    localparam logic [31:0] DEF_ENTRY_TIMEOUT = 32'd60000000;
    localparam logic [31:0] DEF_UNLOCK_TIME   = 32'd120000000;
    localparam logic [7:0]  DEF_CODE          = 8'b0000_0101;

    // The blinker drops done_blinking late, so it is ignored this many cycles after a pulse.
    localparam logic [1:0]  BLINK_IGNORE_CYCLES = 2'd2;

    function automatic logic [7:0] code_mask(input int len);
        logic [7:0] mask;
        mask = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < len) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/lock_timeout_timer.sv
// rtl/lock_timeout_timer.sv - saturating 32-bit cycle counter with clear, enable and limit-reached flag
module lock_timeout_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_limit,
    output logic        o_expired
);

    logic [31:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= 32'd0;
        end else if (i_enable && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Flags the cycle in which the count sits at limit-1; widened so limit=0 cannot wrap.
    assign o_expired = i_enable && (({1'b0, r_count} + 33'd1) >= {1'b0, i_limit});

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - press-code lock FSM with programming mode and blink feedback handshake
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int          CODE_LEN      = 4,
    parameter logic [7:0]  DEFAULT_CODE  = DEF_CODE,
    parameter logic [31:0] ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT,
    parameter logic [31:0] UNLOCK_TIME   = DEF_UNLOCK_TIME
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       press_valid,
    input  logic       press_long,
    input  logic       prog_req,
    input  logic       done_blinking,
    output logic       start_blinking,
    output logic       blink_type,
    output logic       unlocked,
    output logic       busy,
    output logic [3:0] entry_count
);

    localparam logic [7:0] CODE_MASK = code_mask(CODE_LEN);
    localparam logic [3:0] LEN4      = 4'(CODE_LEN);

    state_t     r_state;
    logic [7:0] r_code;
    logic [7:0] r_shift;
    logic [3:0] r_count;
    logic [1:0] r_wait;
    logic       r_start;
    logic       r_type;
    logic       r_unlocked;
    logic       r_busy;

    logic       w_sym;
    logic [7:0] w_shift_ins;
    logic       w_last;
    logic       w_match;
    logic       w_in_entry;
    logic       w_entry_expired;
    logic       w_unlock_expired;

    assign w_sym      = press_long ? SYM_LONG : SYM_SHORT;
    assign w_last     = (r_count + 4'd1) == LEN4;
    assign w_match    = ((r_shift ^ r_code) & CODE_MASK) == 8'd0;
    assign w_in_entry = (r_state == ST_ENTER) || (r_state == ST_PROG_ENTER);

    always_comb begin
        w_shift_ins = r_shift;
        w_shift_ins[r_count[2:0]] = w_sym;
    end

    // A press restarts the idle window, so it always beats a same-cycle timeout.
    lock_timeout_timer u_entry_timer (
        .i_clk     (hwclk),
        .i_rst     (rst),
        .i_clear   (!w_in_entry || press_valid),
        .i_enable  (w_in_entry),
        .i_limit   (ENTRY_TIMEOUT),
        .o_expired (w_entry_expired)
    );

    lock_timeout_timer u_unlock_timer (
        .i_clk     (hwclk),
        .i_rst     (rst),
        .i_clear   (r_state != ST_UNLOCKED),
        .i_enable  (r_state == ST_UNLOCKED),
        .i_limit   (UNLOCK_TIME),
        .o_expired (w_unlock_expired)
    );

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_code     <= DEFAULT_CODE;
            r_shift    <= 8'd0;
            r_count    <= 4'd0;
            r_wait     <= 2'd0;
            r_start    <= 1'b0;
            r_type     <= BLINK_ERROR;
            r_unlocked <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (press_valid) begin
                        r_shift <= {7'd0, w_sym};
                        r_count <= 4'd1;
                        if (CODE_LEN == 1) begin
                            r_state <= ST_CHECK;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_ENTER;
                        end
                    end
                end
                ST_ENTER, ST_PROG_ENTER: begin
                    if (press_valid) begin
                        r_shift <= w_shift_ins;
                        r_count <= r_count + 4'd1;
                        if (w_last) begin
                            r_busy <= 1'b1;
                            if (r_state == ST_ENTER) begin
                                r_state <= ST_CHECK;
                            end else begin
                                r_code     <= w_shift_ins;
                                r_unlocked <= 1'b0;
                                r_type     <= BLINK_PROG_OK;
                                r_start    <= 1'b1;
                                r_state    <= ST_SIGNAL;
                            end
                        end
                    end else if (w_entry_expired) begin
                        r_count    <= 4'd0;
                        r_unlocked <= 1'b0;
                        r_type     <= BLINK_ERROR;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SIGNAL;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_unlocked <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_UNLOCKED;
                    end else begin
                        r_type  <= BLINK_ERROR;
                        r_start <= 1'b1;
                        r_state <= ST_SIGNAL;
                    end
                end
                ST_UNLOCKED: begin
                    if (prog_req) begin
                        r_shift <= 8'd0;
                        r_count <= 4'd0;
                        r_state <= ST_PROG_ENTER;
                    end else if (w_unlock_expired) begin
                        r_unlocked <= 1'b0;
                        r_count    <= 4'd0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_SIGNAL: begin
                    r_wait  <= 2'd0;
                    r_state <= ST_WAIT_BLINK;
                end
                ST_WAIT_BLINK: begin
                    if (r_wait < BLINK_IGNORE_CYCLES) begin
                        r_wait <= r_wait + 2'd1;
                    end else if (done_blinking) begin
                        r_count <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_blinking = r_start;
    assign blink_type     = r_type;
    assign unlocked       = r_unlocked;
    assign busy           = r_busy;
    assign entry_count    = r_count;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed and random stimulus against a behavioural lock model with a blinker stand-in
module tb_lock_sequencer;

    localparam int         CL   = 4;
    localparam int         TO   = 100;
    localparam int         UT   = 200;
    localparam logic [7:0] DEFC = 8'b0000_0101;

    logic       hwclk = 1'b0;
    logic       rst = 1'b1;
    logic       press_valid = 1'b0;
    logic       press_long = 1'b0;
    logic       prog_req = 1'b0;
    logic       done_blinking = 1'b1;
    logic       start_blinking;
    logic       blink_type;
    logic       unlocked;
    logic       busy;
    logic [3:0] entry_count;

    always #5 hwclk = ~hwclk;

    lock_sequencer #(
        .CODE_LEN      (CL),
        .DEFAULT_CODE  (DEFC),
        .ENTRY_TIMEOUT (32'(TO)),
        .UNLOCK_TIME   (32'(UT))
    ) dut (
        .hwclk          (hwclk),
        .rst            (rst),
        .press_valid    (press_valid),
        .press_long     (press_long),
        .prog_req       (prog_req),
        .done_blinking  (done_blinking),
        .start_blinking (start_blinking),
        .blink_type     (blink_type),
        .unlocked       (unlocked),
        .busy           (busy),
        .entry_count    (entry_count)
    );

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_ENTER, M_CHECK, M_OPEN, M_PROG, M_SIGNAL, M_WAIT} mode_t;
    mode_t      m_mode = M_IDLE;
    bit         m_sym[$];
    logic [7:0] m_code = DEFC;
    int         idle_left = TO;
    int         open_left = UT;
    int         wait_age = 0;
    logic       e_unl = 1'b0;
    logic       e_start = 1'b0;
    logic       e_type = 1'b0;
    logic [3:0] e_cnt = 4'd0;

    int blk_cnt = 0;
    bit blk_late = 1'b0;

    function automatic bit m_match();
        for (int i = 0; i < CL; i++) begin
            if (m_sym[i] != m_code[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_sym.delete();
        m_code = DEFC;
        idle_left = TO;
        open_left = UT;
        wait_age = 0;
        e_unl = 1'b0;
        e_start = 1'b0;
        e_type = 1'b0;
        e_cnt = 4'd0;
    endtask

    task automatic signal(input logic t);
        e_type = t;
        e_start = 1'b1;
        m_mode = M_SIGNAL;
    endtask

    task automatic model_step(input bit pv, input bit pl, input bit pr, input bit dn);
        e_start = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (pv) begin
                    m_sym = {pl};
                    e_cnt = 4'd1;
                    idle_left = TO;
                    m_mode = (CL == 1) ? M_CHECK : M_ENTER;
                end
            end
            M_ENTER, M_PROG: begin
                if (pv) begin
                    m_sym.push_back(pl);
                    e_cnt = e_cnt + 4'd1;
                    idle_left = TO;
                    if (m_sym.size() == CL) begin
                        if (m_mode == M_ENTER) begin
                            m_mode = M_CHECK;
                        end else begin
                            for (int i = 0; i < CL; i++) m_code[i] = m_sym[i];
                            e_unl = 1'b0;
                            signal(1'b1);
                        end
                    end
                end else begin
                    idle_left--;
                    if (idle_left == 0) begin
                        m_sym.delete();
                        e_cnt = 4'd0;
                        e_unl = 1'b0;
                        signal(1'b0);
                    end
                end
            end
            M_CHECK: begin
                if (m_match()) begin
                    e_unl = 1'b1;
                    open_left = UT;
                    m_mode = M_OPEN;
                end else begin
                    signal(1'b0);
                end
            end
            M_OPEN: begin
                if (pr) begin
                    m_mode = M_PROG;
                    m_sym.delete();
                    e_cnt = 4'd0;
                    idle_left = TO;
                end else begin
                    open_left--;
                    if (open_left == 0) begin
                        e_unl = 1'b0;
                        e_cnt = 4'd0;
                        m_mode = M_IDLE;
                    end
                end
            end
            M_SIGNAL: begin
                m_mode = M_WAIT;
                wait_age = 0;
            end
            M_WAIT: begin
                if (wait_age >= 2 && dn) begin
                    m_mode = M_IDLE;
                    e_cnt = 4'd0;
                end else begin
                    wait_age++;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit pv, input bit pl, input bit pr, input bit rs);
        if (blk_late) begin
            done_blinking = 1'b1;
            blk_late = 1'b0;
        end else if (blk_cnt > 0) begin
            done_blinking = 1'b0;
            blk_cnt--;
        end else begin
            done_blinking = 1'b1;
        end
        press_valid = pv;
        press_long = pl;
        prog_req = pr;
        rst = rs;
        @(posedge hwclk);
        if (rs) model_reset();
        else model_step(pv, pl, pr, done_blinking);
        #1;
        chk("unlocked", 32'(unlocked), 32'(e_unl));
        chk("start_blinking", 32'(start_blinking), 32'(e_start));
        chk("blink_type", 32'(blink_type), 32'(e_type));
        chk("busy", 32'(busy), 32'(m_mode == M_CHECK || m_mode == M_SIGNAL || m_mode == M_WAIT));
        chk("entry_count", 32'(entry_count), 32'(e_cnt));
        if (start_blinking) begin
            blk_late = 1'b1;
            blk_cnt = $urandom_range(1, 12);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [3:0] c, input int gap);
        for (int i = 0; i < CL; i++) begin
            step(1'b1, c[i], 1'b0, 1'b0);
            if (i < CL - 1) idle(gap);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && m_mode != M_IDLE; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

        // L,S,L,S with default code: unlock window then relock
        enter_code(4'b0101, 9);
        idle(205);

        // wrong code: error blink and busy until blinker done
        enter_code(4'b1111, 9);
        wait_idle();

        // program S,S,L,L, then old code fails and new code unlocks
        enter_code(4'b0101, 9);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        enter_code(4'b1100, 9);
        wait_idle();
        enter_code(4'b0101, 9);
        wait_idle();
        enter_code(4'b1100, 9);
        idle(205);

        // entry timeout after a single press
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(100);
        wait_idle();

        // press on idle cycle 99 keeps the entry alive; code S,L,S,L mismatches 1100
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(98);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(30);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // press in the exact timeout cycle wins, then a real timeout
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !(m_mode == M_ENTER && idle_left == 1); i++) idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(100);
        wait_idle();

        // ignored inputs: presses while blinking, prog_req while locked
        enter_code(4'b1111, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(110);
        wait_idle();

        // prog_req and press together in the unlock-expiry cycle: programming wins
        enter_code(4'b1100, 3);
        for (int i = 0; i < 300 && !(m_mode == M_OPEN && open_left == 1); i++) idle(1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        enter_code(4'b0101, 4);
        wait_idle();

        // reprogram to 1100, reset after three symbols, default code works again
        enter_code(4'b0101, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        enter_code(4'b1100, 2);
        wait_idle();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        enter_code(4'b0101, 9);
        idle(205);

        // random traffic, sometimes entering the model's current code
        for (int seg = 0; seg < 40; seg++) begin
            if (m_mode == M_IDLE && $urandom_range(0, 1) == 0)
                enter_code(m_code[3:0], $urandom_range(0, 12));
            for (int i = 0; i < 80; i++)
                step($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 999) == 0);
            if ($urandom_range(0, 2) == 0) idle(120);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
